// File: rtl/lector_tablero.sv
// Board status reader: sweeps all 64 cells in row-major order, then reports
// revealed/flag counts plus win/loss status with a one-cycle done pulse.
module lector_tablero (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] cantBombas,
  input  logic [6:0] celda,
  output logic [2:0] i_lect,
  output logic [2:0] j_lect,
  output logic       busy,
  output logic       done,
  output logic       perdio,
  output logic       gano,
  output logic [6:0] banderas,
  output logic [6:0] reveladas
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned CELLS = 64;

  localparam int unsigned BIT_BOMB   = 6;
  localparam int unsigned BIT_FLAG   = 5;
  localparam int unsigned BIT_REVEAL = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic [CNT_W-1:0]   flag_cnt_q, flag_cnt_d;
  logic               hit_q, hit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               perdio_q, perdio_d;
  logic               gano_q, gano_d;
  logic [CNT_W-1:0]   banderas_q, banderas_d;
  logic [CNT_W-1:0]   reveladas_q, reveladas_d;

  // Neighbor count is carried on the cell bus but plays no part in status.
  logic celda_unused;
  assign celda_unused = ^celda[3:0];

  // Next-state, counters and result logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rev_cnt_d   = rev_cnt_q;
    flag_cnt_d  = flag_cnt_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    perdio_d    = perdio_q;
    gano_d      = gano_q;
    banderas_d  = banderas_q;
    reveladas_d = reveladas_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          idx_d      = '0;
          rev_cnt_d  = '0;
          flag_cnt_d = '0;
          hit_d      = 1'b0;
        end
      end
      SCAN: begin
        if (celda[BIT_REVEAL]) rev_cnt_d = rev_cnt_q + CNT_W'(1);
        if (celda[BIT_FLAG])   flag_cnt_d = flag_cnt_q + CNT_W'(1);
        if (celda[BIT_BOMB] && celda[BIT_REVEAL]) hit_d = 1'b1;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(CELLS - 1)) state_d = EVAL;
      end
      EVAL: begin
        reveladas_d = rev_cnt_q;
        banderas_d  = flag_cnt_q;
        perdio_d    = hit_q;
        gano_d      = !hit_q &&
                      (rev_cnt_q == (CNT_W'(CELLS) - {1'b0, cantBombas}));
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address and busy follow the upcoming state so they line up with celda.
    busy_d = (state_d != IDLE);
    addr_d = (state_d == SCAN) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      rev_cnt_q   <= '0;
      flag_cnt_q  <= '0;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      perdio_q    <= 1'b0;
      gano_q      <= 1'b0;
      banderas_q  <= '0;
      reveladas_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      rev_cnt_q   <= rev_cnt_d;
      flag_cnt_q  <= flag_cnt_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      perdio_q    <= perdio_d;
      gano_q      <= gano_d;
      banderas_q  <= banderas_d;
      reveladas_q <= reveladas_d;
    end
  end

  assign i_lect    = addr_q[5:3];
  assign j_lect    = addr_q[2:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign perdio    = perdio_q;
  assign gano      = gano_q;
  assign banderas  = banderas_q;
  assign reveladas = reveladas_q;

endmodule

// File: tb/tb_lector_tablero.sv
// Directed bench for lector_tablero: a behavioural board feeds celda from the
// read address; expected counts and status are hand-derived per board.
module tb_lector_tablero;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] cantBombas;
  logic [6:0] celda;
  logic [2:0] i_lect;
  logic [2:0] j_lect;
  logic       busy;
  logic       done;
  logic       perdio;
  logic       gano;
  logic [6:0] banderas;
  logic [6:0] reveladas;

  logic [6:0] board [64];

  int vectors;
  int miscompares;

  localparam logic [6:0] C_BOMB   = 7'b1000000;
  localparam logic [6:0] C_FLAG   = 7'b0100000;
  localparam logic [6:0] C_REVEAL = 7'b0010000;

  lector_tablero dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cantBombas (cantBombas),
    .celda      (celda),
    .i_lect     (i_lect),
    .j_lect     (j_lect),
    .busy       (busy),
    .done       (done),
    .perdio     (perdio),
    .gano       (gano),
    .banderas   (banderas),
    .reveladas  (reveladas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign celda = board[{i_lect, j_lect}];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every cell gets a random neighbor nibble to prove it is ignored.
  task automatic fill_board(input logic [6:0] base);
    for (int c = 0; c < 64; c++) board[c] = base | 7'($urandom_range(0, 8));
  endtask

  task automatic board_a();
    fill_board(C_REVEAL);
    board[34] = C_BOMB | C_FLAG | 7'd2;
    board[44] = C_BOMB | 7'd1;
  endtask

  // One start pulse, then check latency, sweep, busy length and results.
  task automatic run_scan(input string tag, input int exp_rev, input int exp_ban,
                          input int exp_per, input int exp_gan);
    int n;
    int busy_cnt;
    int sweep_err;
    logic [6:0] r_rev;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    sweep_err = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      if (n <= 64) begin
        if ({i_lect, j_lect} != 6'(n - 1)) sweep_err++;
      end else if ({i_lect, j_lect} != 6'd0) sweep_err++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 66);
    chk({tag, "_busy_len"}, busy_cnt, 65);
    chk({tag, "_sweep_err"}, sweep_err, 0);
    chk({tag, "_rev"}, reveladas, exp_rev);
    chk({tag, "_ban"}, banderas, exp_ban);
    chk({tag, "_perdio"}, perdio, exp_per);
    chk({tag, "_gano"}, gano, exp_gan);
    r_rev = reveladas;
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold_rev"}, reveladas, 32'(r_rev));
    chk({tag, "_idle_addr"}, {i_lect, j_lect, busy}, 0);
  endtask

  initial begin
    int n;
    int m;
    int dones;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    cantBombas = 6'd0;
    fill_board(7'd0);
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, perdio, gano, banderas, reveladas, i_lect, j_lect}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Empty board: nothing revealed, 5 bombs -> no win.
    cantBombas = 6'd5;
    run_scan("empty", 0, 0, 0, 0);

    // 62 safe cells revealed, one bomb flagged -> win.
    board_a();
    cantBombas = 6'd2;
    run_scan("win", 62, 1, 0, 1);

    // Second bomb revealed -> loss overrides.
    board[44] = C_BOMB | C_REVEAL;
    run_scan("lose", 63, 1, 1, 0);

    // No bombs, every cell revealed and flagged -> win with full 7-bit counts.
    fill_board(C_REVEAL | C_FLAG);
    cantBombas = 6'd0;
    run_scan("full", 64, 64, 0, 1);

    // No bombs but one cell hidden -> no win.
    board[63] = C_FLAG;
    run_scan("nobomb_hidden", 63, 64, 0, 0);

    // Reset at scan cycle 30 aborts without done, then a fresh scan.
    board_a();
    board[44] = C_BOMB | C_REVEAL;
    cantBombas = 6'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 80; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    chk("abort_cleared", {busy, perdio, gano, banderas, reveladas, i_lect, j_lect}, 0);
    board[44] = C_BOMB;
    run_scan("after_abort", 62, 1, 0, 1);

    // start held high: back-to-back scans every 66 cycles, identical results.
    start = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_lat", n, 66);
    m = 0;
    @(negedge clk);
    m++;
    while (!done && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_period", m, 66);
    chk("b2b_rev", reveladas, 62);
    chk("b2b_gano", gano, 1);
    start = 1'b0;
    repeat (70) @(negedge clk);
    chk("b2b_stopped", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lector_tablero.md
LECTOR_TABLERO -- requirements
Module: lector_tablero

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-005 Port cantBombas, input, 6 bits: number of bombs on the board (0..63).
REQ-006 Port celda, input, 7 bits: cell data for the addressed cell, supplied combinationally in the same cycle. Bit 6 = bomb, bit 5 = flag, bit 4 = revealed, bits 3:0 = neighbor count (ignored).
REQ-007 Port i_lect, output, 3 bits: row address of the cell being read.
REQ-008 Port j_lect, output, 3 bits: column address of the cell being read.
REQ-009 Port busy, output, 1 bit: high in SCAN and EVAL.
REQ-010 Port done, output, 1 bit: one-cycle pulse when results update.
REQ-011 Port perdio, output, 1 bit: a revealed bomb exists.
REQ-012 Port gano, output, 1 bit: all safe cells are revealed and no bomb is revealed.
REQ-013 Port banderas, output, 7 bits: count of flagged cells (0..64).
REQ-014 Port reveladas, output, 7 bits: count of revealed cells (0..64).

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and EVAL; state encoding is free.
REQ-016 In IDLE with start=1, the block SHALL go to SCAN, clear the 6-bit index and clear the internal counters and bomb-hit flag.
REQ-017 In IDLE with start=0, the block SHALL stay in IDLE with outputs held.
REQ-018 i_lect SHALL equal index[5:3] and j_lect SHALL equal index[2:0] (row-major order); both are 0 outside SCAN.
REQ-019 Each SCAN cycle SHALL sample celda for the current index:
- increment the revealed count if bit4=1;
- increment the flag count if bit5=1;
- set the bomb-hit flag if bit6=1 and bit4=1;
- then increment the index.
REQ-020 SCAN SHALL last exactly 64 cycles; after sampling index 63 the FSM SHALL go to EVAL. The index wraps 63->0, and the wrap has no effect.
REQ-021 In EVAL (one cycle) the block SHALL register the results and return to IDLE:
- reveladas and banderas take the internal counts;
- perdio takes the bomb-hit flag;
- gano = !bomb-hit && (reveladas == 64 - cantBombas), computed in 7 bits.
REQ-022 done SHALL be high for exactly the one cycle following the EVAL edge.
REQ-023 Latency: with start sampled at edge k, cells are sampled at edges k+1..k+64, results update at edge k+65, and done is high during the cycle after edge k+65.
REQ-024 start SHALL be ignored while busy; a start in the same cycle done is high SHALL begin a new scan.
REQ-025 perdio=1 SHALL force gano=0.
REQ-026 With cantBombas=0, gano=1 only if reveladas=64.
REQ-027 The counters SHALL be 7 bits and reach 64 without overflow.
REQ-028 Outputs perdio, gano, banderas and reveladas SHALL hold their values between done pulses.

Reset
REQ-029 rst=1 SHALL force state IDLE, index 0, all counters 0, bomb-hit 0, busy=0, done=0, perdio=0, gano=0, banderas=0, reveladas=0, i_lect=0 and j_lect=0.
REQ-030 rst in any state, including mid-SCAN or EVAL, SHALL abort the scan without a done pulse; rst has priority over start.

Verification
REQ-031 Empty board (all celda=0), cantBombas=5, start pulse -> done exactly 66 cycles after start; reveladas=0, banderas=0, gano=0, perdio=0.
REQ-032 Bombs at (4,2),(5,4), cantBombas=2, all 62 other cells revealed, (4,2) flagged -> gano=1, perdio=0, reveladas=62, banderas=1.
REQ-033 Same board with (5,4) also revealed -> perdio=1, gano=0, reveladas=63.
REQ-034 Address sweep check -> i_lect/j_lect step (0,0),(0,1)..(0,7),(1,0)..(7,7) once each, then return to 0; busy high for 65 cycles.
REQ-035 rst asserted at scan cycle 30, then start -> no done from the first scan; second scan reports fresh counts only.
REQ-036 start held high continuously -> back-to-back scans, one done every 66 cycles, results identical for a static board.
